morse_rx_stream: RTL and testbench
==================================

# morse_rx_stream

Parametrised single-clock Morse receiver: times the keyed `signal` directly, classifies marks as dit or dah, and decodes complete characters to ASCII through an internal International Morse table. It emits a space character on word gaps. Decoded characters go into a FIFO with a valid/ready output handshake. It is the streaming successor to the fixed-width capture-and-decode word path: it replaces the `MAX_CHARS` word register with a character stream that has back-pressure and sticky overflow reporting.

## Interface
- `CNT_W`, 16: width of the pulse counter and of all timing inputs.
- `MAX_LEN`, 6: maximum dits/dahs per character, legal range 5..8.
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  system clock; every register is on its rising edge.
- `aclr`  in  1  asynchronous reset, active-low; resets all state.
- `ce`  in  1  timing clock enable; counters and the FSM advance only when `ce`=1.
- `dit_time`, `dah_time`  in  CNT_W  nominal mark lengths, in `ce` ticks.
- `char_time`  in  CNT_W  space length that closes a character.
- `word_time`  in  CNT_W  space length that closes a word; `word_time` > `char_time`.
- `tol_time`  in  CNT_W  ± tolerance used for mark classification.
- `signal`  in  1  keyed input, already synchronous to `clk`; 1 = mark.
- `m_data`  out  8  head-of-FIFO ASCII character.
- `m_err`  out  1  error flag of the head entry.
- `m_valid`  out  1  the FIFO is not empty.
- `m_ready`  in  1  consumer accepts the head entry.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  number of occupied entries.
- `ovf`  out  1  sticky flag: at least one entry was dropped because the FIFO was full.
- `ovf_clr`  in  1  synchronous clear for `ovf`.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- **Sampling.** `signal` is sampled on `ce` cycles only. `cnt` counts `ce` ticks at the current level, restarts at 1 on each level change, and saturates at 2^CNT_W−1.
- **FSM state IDLE.** Entered at reset. A ce-sample of 0 arms the receiver, and a subsequent ce-sample of 1 moves to MARK. A mark already present when reset is released is ignored until it ends.
- **FSM state MARK.** When `signal` falls, the mark length L = `cnt` is classified:
  - dit if |L−`dit_time`| ≤ `tol_time`;
  - otherwise dah if |L−`dah_time`| ≤ `tol_time`;
  - otherwise the character error bit is set and no symbol is stored.
  - Comparisons are done in CNT_W+1 bits with no wrap-around.
  - A stored symbol goes into `sym[len]` (0 = dit, 1 = dah) and `len` increments. If `len` = MAX_LEN, the symbol is discarded and the error bit is set.
  - The FSM then goes to SPACE.
- **FSM state SPACE.**
  - A rising `signal` returns to MARK and continues the current character.
  - When `cnt` reaches `char_time`, the character is pushed to the FIFO, `len` and the error bit are cleared, and the FSM goes to WGAP.
- **FSM state WGAP.**
  - A rising `signal` goes to MARK and starts a new character.
  - When `cnt` reaches `word_time`, 0x20 with err=0 is pushed and the FSM goes to IDLE (armed). Only one space is emitted per gap.
- **Decode.**
  - A–Z map to 0x41–0x5A and 0–9 map to 0x30–0x39, using the standard International Morse codes.
  - If the error bit is set, the character is 0x2A ('*') with err=1.
  - A valid but unmapped pattern is 0x3F ('?') with err=1.
- **FIFO.**
  - Push is blocked when full; the entry is dropped and `ovf` is set.
  - Pop happens on `m_valid & m_ready`.
  - A push and a pop in the same cycle both succeed, including when the FIFO is full. In that case `ovf` is not set and `fifo_level` is unchanged.
  - The read pointer wraps modulo FIFO_DEPTH.
- **ovf.** `ovf_clr` clears `ovf` the next cycle. If a drop occurs in the same cycle as `ovf_clr`, `ovf` stays 1.

## Timing
- **Reset values.** All of `m_valid`, `m_err`, `m_data`, `fifo_level`, `ovf`, `busy` are 0. The FSM is in IDLE, unarmed. `cnt` and `len` are 0.
- **Reset mid-operation.** `aclr` asserted at any point discards any partial character and all FIFO contents immediately, without waiting for a clock edge.
- **Push latency.** A push happens on the `clk` edge of the ce-cycle where `cnt` hits its threshold. `m_valid` and `fifo_level` update on the next edge. There is no fall-through.
- **Mark classification** takes effect on the edge of the ce-cycle that samples the falling edge.
- **Handshake.** `m_data` and `m_err` are stable while `m_valid`=1 and `m_ready`=0. After a pop, the next entry appears one cycle later.
- **`ce`=0.** The FSM and `cnt` hold. The FIFO handshake, `ovf_clr` and pops still operate every `clk`.
- **`busy`** is registered and reflects the FSM state after each edge.

## Test plan
- Common settings: dit=10, dah=30, tol=3, char=30, word=70; `ce` always 1 unless stated.
- Case 1: mark 10, space 10, mark 30, space 30, `m_ready`=1 → one entry 0x41 ('A'), err=0; `m_valid` high exactly one cycle after the char threshold.
- Case 2: SOS with 10-tick intra gaps and 30-tick char gaps, then 80-tick silence → 0x53, 0x4F, 0x53, 0x20 in order; no second 0x20.
- Case 3: mark 20, then space 30 → 0x2A, err=1. Separately, pattern `.-.-` → 0x3F, err=1.
- Case 4: MAX_LEN=5, seven dits then space 30 → 0x2A, err=1; next character decodes normally.
- Case 5: FIFO_DEPTH=4, `m_ready`=0, send 6 'E's →
  - `fifo_level`=4 and `ovf`=1;
  - after raising `m_ready`, exactly 4 entries of 0x45 are read;
  - `ovf_clr` then clears `ovf`.
- Case 6: assert `aclr` mid-mark with 2 entries queued →
  - all outputs read 0 immediately;
  - after release, a mark already in progress is ignored;
  - the next clean 'T' yields 0x54.

Source files
------------

// File: rtl/morse_rx_stream.sv
// ============================================================================
// Module   : morse_rx_stream
// Purpose  : Morse receiver. Times the keyed signal in ce ticks, classifies
//            marks as dit/dah, decodes characters to ASCII and streams them
//            (plus a space on word gaps) through a valid/ready FIFO with a
//            sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_rx_stream #(
    parameter int CNT_W      = 16,
    parameter int MAX_LEN    = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              aclr,
    input  logic                              ce,
    input  logic [CNT_W-1:0]                  dit_time,
    input  logic [CNT_W-1:0]                  dah_time,
    input  logic [CNT_W-1:0]                  char_time,
    input  logic [CNT_W-1:0]                  word_time,
    input  logic [CNT_W-1:0]                  tol_time,
    input  logic                              signal,
    output logic [7:0]                        m_data,
    output logic                              m_err,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              ovf,
    input  logic                              ovf_clr,
    output logic                              busy
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_WGAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic               sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] sym_q, sym_d;
    logic               err_q, err_d;
    logic               push_q, push_d;
    logic [7:0]         pdata_q, pdata_d;
    logic               perr_q, perr_d;

    logic [8:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [LVL_W-1:0]   count_q;
    logic               ovf_q;

    logic               dit_ok, dah_ok;
    logic [8:0]         dec;
    logic               full, pop, wr, drop;

    // Distance between two timing values, widened so nothing wraps.
    function automatic logic [CNT_W:0] absdiff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] ea, eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    // Symbol list (sym[0] sent first) to {unmapped, ascii}. The key is a
    // leading 1 followed by the symbols in send order, dah = 1.
    function automatic logic [8:0] decode(input logic [LEN_W-1:0]   n,
                                          input logic [MAX_LEN-1:0] s);
        logic [8:0] key;
        logic [7:0] ch;
        key = 9'd1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(n)) key = {key[7:0], s[i]};
        end
        case (key)
            9'd5:  ch = "A";  9'd24: ch = "B";  9'd26: ch = "C";  9'd12: ch = "D";
            9'd2:  ch = "E";  9'd18: ch = "F";  9'd14: ch = "G";  9'd16: ch = "H";
            9'd4:  ch = "I";  9'd23: ch = "J";  9'd13: ch = "K";  9'd20: ch = "L";
            9'd7:  ch = "M";  9'd6:  ch = "N";  9'd15: ch = "O";  9'd22: ch = "P";
            9'd29: ch = "Q";  9'd10: ch = "R";  9'd8:  ch = "S";  9'd3:  ch = "T";
            9'd9:  ch = "U";  9'd17: ch = "V";  9'd11: ch = "W";  9'd25: ch = "X";
            9'd27: ch = "Y";  9'd28: ch = "Z";
            9'd63: ch = "0";  9'd47: ch = "1";  9'd39: ch = "2";  9'd35: ch = "3";
            9'd33: ch = "4";  9'd32: ch = "5";  9'd48: ch = "6";  9'd56: ch = "7";
            9'd60: ch = "8";  9'd62: ch = "9";
            default: ch = 8'h3F;
        endcase
        if (int'(n) > 5) ch = 8'h3F;
        return {(ch == 8'h3F), ch};
    endfunction

    assign dit_ok = absdiff(cnt_q, dit_time) <= {1'b0, tol_time};
    assign dah_ok = absdiff(cnt_q, dah_time) <= {1'b0, tol_time};
    assign dec    = decode(len_q, sym_q);

    // Level-run counter: restarts at 1 on a level change, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        sig_d = sig_q;
        if (ce) begin
            sig_d = signal;
            if (signal != sig_q)          cnt_d = CNT_W'(1);
            else if (cnt_q != '1)         cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Receiver FSM: mark classification, character and word gap detection.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        len_d   = len_q;
        sym_d   = sym_q;
        err_d   = err_q;
        push_d  = 1'b0;
        pdata_d = pdata_q;
        perr_d  = perr_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    // A mark only counts once a space has been seen first.
                    if (!signal) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d = 1'b0;
                        state_d = S_MARK;
                    end
                end
                S_MARK: begin
                    if (!signal) begin
                        if (dit_ok || dah_ok) begin
                            if (int'(len_q) == MAX_LEN) begin
                                err_d = 1'b1;
                            end else begin
                                for (int i = 0; i < MAX_LEN; i++) begin
                                    if (i == int'(len_q)) sym_d[i] = ~dit_ok;
                                end
                                len_d = len_q + LEN_W'(1);
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = S_SPACE;
                    end
                end
                S_SPACE: begin
                    if (signal) begin
                        state_d = S_MARK;
                    end else if (cnt_d == char_time) begin
                        push_d  = 1'b1;
                        pdata_d = err_q ? 8'h2A : dec[7:0];
                        perr_d  = err_q | dec[8];
                        len_d   = '0;
                        sym_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_WGAP;
                    end
                end
                default: begin
                    if (signal) begin
                        state_d = S_MARK;
                    end else if (cnt_d == word_time) begin
                        push_d  = 1'b1;
                        pdata_d = 8'h20;
                        perr_d  = 1'b0;
                        armed_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            sig_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            sym_q   <= '0;
            err_q   <= 1'b0;
            push_q  <= 1'b0;
            pdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sym_q   <= sym_d;
            err_q   <= err_d;
            push_q  <= push_d;
            pdata_q <= pdata_d;
            perr_q  <= perr_d;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full = (count_q == LVL_W'(FIFO_DEPTH));
    assign pop  = m_valid & m_ready;
    assign wr   = push_q & (~full | pop);
    assign drop = push_q & full & ~pop;

    // FIFO storage; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= {perr_q, pdata_q};
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr)  wr_q <= wr_q + PTR_W'(1);
            if (pop) rd_q <= rd_q + PTR_W'(1);
            count_q <= count_q + LVL_W'(wr) - LVL_W'(pop);
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign m_valid    = (count_q != '0);
    assign m_data     = m_valid ? mem_q[rd_q][7:0] : 8'h00;
    assign m_err      = m_valid ? mem_q[rd_q][8]   : 1'b0;
    assign fifo_level = count_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_morse_rx_stream.sv
// ============================================================================
// Module   : tb_morse_rx_stream
// Purpose  : Self-checking bench for morse_rx_stream: directed cases plus
//            randomized characters against a table-driven reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_rx_stream;

    localparam int CNT_W   = 16;
    localparam int MAX_LEN = 5;
    localparam int DEPTH   = 4;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int DIT = 10, DAH = 30, TOL = 3, CHR = 30, WRD = 70;

    logic             clk = 1'b0;
    logic             aclr, ce, sig, m_ready, ovf_clr;
    logic [7:0]       m_data;
    logic             m_err, m_valid, ovf, busy;
    logic [LVL_W-1:0] fifo_level;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    bit  rnd_ce = 1'b0;
    bit  rnd_rdy = 1'b0;
    logic [8:0] exp_q[$];

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."};

    morse_rx_stream #(.CNT_W(CNT_W), .MAX_LEN(MAX_LEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .aclr(aclr), .ce(ce),
        .dit_time(16'(DIT)), .dah_time(16'(DAH)), .char_time(16'(CHR)),
        .word_time(16'(WRD)), .tol_time(16'(TOL)),
        .signal(sig), .m_data(m_data), .m_err(m_err), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_level(fifo_level), .ovf(ovf),
        .ovf_clr(ovf_clr), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs_v,
                           input logic [31:0] exp_v);
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Expected {err, ascii} for one character given its mark lengths.
    function automatic logic [8:0] model_char(input int lens[$]);
        string s;
        bit    bad;
        s   = "";
        bad = 1'b0;
        foreach (lens[i]) begin
            if (iabs(lens[i] - DIT) <= TOL)      s = {s, "."};
            else if (iabs(lens[i] - DAH) <= TOL) s = {s, "-"};
            else                                 bad = 1'b1;
        end
        if (s.len() > MAX_LEN) bad = 1'b1;
        if (bad) return {1'b1, 8'h2A};
        for (int i = 0; i < 36; i++) begin
            if (morse_tab[i] == s)
                return {1'b0, (i < 26) ? 8'(65 + i) : 8'(48 + i - 26)};
        end
        return {1'b1, 8'h3F};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    endtask

    // Hold a level for n ce ticks.
    task automatic drive(input logic lvl, input int n);
        int k;
        k   = 0;
        sig = lvl;
        while (k < n) begin
            ce = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ce) k++;
            tick();
        end
    endtask

    task automatic send_marks(input int lens[$], input int intra, input int gap);
        if (gap >= CHR) exp_q.push_back(model_char(lens));
        if (gap >= WRD) exp_q.push_back({1'b0, 8'h20});
        foreach (lens[i]) begin
            drive(1'b1, lens[i]);
            drive(1'b0, (i == lens.size() - 1) ? gap : intra);
        end
    endtask

    task automatic send_code(input string code, input int gap);
        int lens[$];
        for (int i = 0; i < code.len(); i++)
            lens.push_back((code[i] == 8'h2D) ? DAH : DIT);
        send_marks(lens, 10, gap);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            tick();
            t++;
        end
        chk_val(tag, exp_q.size(), 0);
    endtask

    // Consumer-side scoreboard: every accepted entry must match the model.
    always @(negedge clk) begin
        if (mon_en && aclr && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk_val("unexpected_entry", {23'd0, m_err, m_data}, 32'h1FF);
            end else begin
                chk_val("stream_entry", {23'd0, m_err, m_data}, {23'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int lens[$];
        int got, nsym, gap;
        aclr = 1'b0; ce = 1'b1; sig = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        chk_val("rst_valid", m_valid, 0);
        chk_val("rst_data", m_data, 0);
        chk_val("rst_level", fifo_level, 0);
        chk_val("rst_ovf", ovf, 0);
        chk_val("rst_busy", busy, 0);
        aclr = 1'b1;
        m_ready = 1'b1;
        mon_en = 1'b1;
        drive(1'b0, 5);

        // Case 1: 'A' and its output latency
        exp_q.push_back({1'b0, 8'h41});
        drive(1'b1, 10); drive(1'b0, 10); drive(1'b1, 30); drive(1'b0, 30);
        chk_val("c1_no_fallthru", m_valid, 0);
        tick();
        chk_val("c1_valid", m_valid, 1);
        chk_val("c1_data", m_data, 8'h41);
        chk_val("c1_err", m_err, 0);
        chk_val("c1_level", fifo_level, 1);
        tick();
        chk_val("c1_popped", m_valid, 0);

        // Case 2: SOS then long silence, single space
        send_code("...", 30); send_code("---", 30); send_code("...", 80);
        drive(1'b0, 80);
        chk_val("c2_drained", exp_q.size(), 0);
        chk_val("c2_no_2nd_space", m_valid, 0);
        chk_val("c2_idle", busy, 0);

        // Case 3: bad mark length, unmapped pattern
        lens = '{20};
        send_marks(lens, 10, 30);
        send_code(".-.-", 30);

        // Case 4: too many symbols, then a normal character
        send_code(".......", 30);
        send_code("-.", 80);
        drain("c4_drained");

        // Randomized characters, random ready and ce
        rnd_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rnd_ce = (c % 2 == 1);
            lens.delete();
            nsym = $urandom_range(1, 6);
            for (int s = 0; s < nsym; s++) begin
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       lens.push_back($urandom_range(1, DIT - TOL - 1));
                        1:       lens.push_back($urandom_range(DIT + TOL + 1, DAH - TOL - 1));
                        default: lens.push_back($urandom_range(DAH + TOL + 1, 45));
                    endcase
                end else begin
                    lens.push_back(($urandom_range(0, 1) ? DAH : DIT)
                                   + $urandom_range(0, 2 * TOL) - TOL);
                end
            end
            gap = (c == 29) ? 80 : $urandom_range(CHR, 90);
            send_marks(lens, $urandom_range(1, CHR - 1), gap);
        end
        rnd_rdy = 1'b0; rnd_ce = 1'b0; ce = 1'b1; m_ready = 1'b1;
        drain("rand_drained");
        chk_val("rand_no_ovf", ovf, 0);

        // Case 5: overflow with a stalled consumer
        mon_en = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_code(".", 30);
        exp_q.delete();
        ce = 1'b0;
        tick(); tick();
        chk_val("c5_level", fifo_level, 4);
        chk_val("c5_ovf", ovf, 1);
        m_ready = 1'b1;
        got = 0;
        repeat (12) begin
            if (m_valid) begin
                chk_val("c5_data", m_data, 8'h45);
                got++;
            end
            tick();
        end
        chk_val("c5_count", got, 4);
        chk_val("c5_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk_val("c5_ovf_clr", ovf, 0);

        // Case 6: async reset mid-mark with entries queued
        ce = 1'b1;
        m_ready = 1'b0;
        send_code(".", 30); send_code(".", 30);
        exp_q.delete();
        drive(1'b1, 5);
        chk_val("c6_level_before", fifo_level, 2);
        #2 aclr = 1'b0;
        #1;
        chk_val("c6_valid", m_valid, 0);
        chk_val("c6_data", m_data, 0);
        chk_val("c6_err", m_err, 0);
        chk_val("c6_level", fifo_level, 0);
        chk_val("c6_ovf", ovf, 0);
        chk_val("c6_busy", busy, 0);
        @(posedge clk); #3 aclr = 1'b1;
        tick();
        m_ready = 1'b1;
        mon_en = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 40);
        chk_val("c6_stale_mark", fifo_level, 0);
        send_code("-", 80);
        drain("c6_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
